// File: rtl/mem_wb_ctrl_pkg.sv
// Shared types and constants for the Wishbone-to-byte-memory controller.
// Lane L of the 32-bit bus maps to byte offset 3-L (big-endian).
package mem_wb_ctrl_pkg;

    localparam int AW_DEF   = 14;
    localparam int MEM_SIZE = 1 << AW_DEF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_TERM  = 2'd3
    } state_t;

    function automatic logic [1:0] lane_off(input logic [1:0] lane);
        return 2'd3 - lane;
    endfunction

endpackage

// File: rtl/mem_wb_ctrl_lane_pick.sv
// Priority encoder: picks the highest pending byte lane and
// returns the mask with that lane cleared.
module mem_lane_pick (
    input  logic [3:0] i_mask,
    output logic [1:0] o_lane,
    output logic       o_vld,
    output logic [3:0] o_rest
);

    always_comb begin
        o_lane = 2'd0;
        if (i_mask[3])
            o_lane = 2'd3;
        else if (i_mask[2])
            o_lane = 2'd2;
        else if (i_mask[1])
            o_lane = 2'd1;
    end

    assign o_vld  = |i_mask;
    assign o_rest = i_mask & ~(4'b0001 << o_lane);

endmodule

// File: rtl/mem_wb_ctrl.sv
// Wishbone slave that splits word/half/byte accesses into
// sequential byte accesses on a 1-cycle-latency byte memory.
module mem_wb_ctrl
    import mem_wb_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [31:0]   wb_adr_i,
    input  logic [3:0]    wb_sel_i,
    input  logic [31:0]   wb_dat_i,
    output logic [31:0]   wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic [AW-1:0] mem_adr,
    output logic [7:0]    mem_dat_o,
    input  logic [7:0]    mem_dat_i,
    output logic          mem_en,
    output logic          mem_we
);

    state_t        r_state;
    state_t        w_next;
    logic [AW-3:0] r_word;
    logic [3:0]    r_pend;
    logic          r_we;
    logic          r_err;
    logic [31:0]   r_dat;
    logic [31:0]   r_rdat;
    logic          r_cap_vld;
    logic [1:0]    r_cap_lane;

    logic [1:0]    w_lane;
    logic          w_vld;
    logic [3:0]    w_rest;
    logic          w_req;
    logic          w_adr_err;
    logic [7:0]    w_byte;
    logic          w_unused;

    assign w_req     = wb_cyc_i && wb_stb_i;
    assign w_adr_err = |wb_adr_i[31:AW];
    assign w_unused  = ^wb_adr_i[1:0];

    mem_lane_pick u_pick (
        .i_mask (r_pend),
        .o_lane (w_lane),
        .o_vld  (w_vld),
        .o_rest (w_rest)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_req)
                    w_next = (w_adr_err || wb_sel_i == 4'd0) ?
                             S_TERM : S_ISSUE;
            end
            S_ISSUE: begin
                if (!wb_cyc_i)
                    w_next = S_IDLE;
                else if (w_rest == 4'd0)
                    w_next = r_we ? S_TERM : S_WAIT;
            end
            S_WAIT:  w_next = wb_cyc_i ? S_TERM : S_IDLE;
            S_TERM:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_byte = r_dat[7:0];
        unique case (w_lane)
            2'd3:    w_byte = r_dat[31:24];
            2'd2:    w_byte = r_dat[23:16];
            2'd1:    w_byte = r_dat[15:8];
            default: w_byte = r_dat[7:0];
        endcase
    end

    always_comb begin
        mem_en    = (r_state == S_ISSUE) && w_vld;
        mem_we    = mem_en && r_we;
        mem_adr   = '0;
        mem_dat_o = 8'd0;
        if (mem_en) begin
            mem_adr   = {r_word, lane_off(w_lane)};
            mem_dat_o = w_byte;
        end
        wb_ack_o  = (r_state == S_TERM) && !r_err;
        wb_err_o  = (r_state == S_TERM) && r_err;
        wb_dat_o  = r_rdat;
    end

    // Read bytes arrive one cycle after issue, overlapping the next issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word     <= '0;
            r_pend     <= 4'd0;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_dat      <= 32'd0;
            r_rdat     <= 32'd0;
            r_cap_vld  <= 1'b0;
            r_cap_lane <= 2'd0;
        end else begin
            r_cap_vld <= 1'b0;
            if (r_state == S_IDLE && w_req) begin
                r_word <= wb_adr_i[AW-1:2];
                r_pend <= wb_sel_i;
                r_we   <= wb_we_i;
                r_dat  <= wb_dat_i;
                r_err  <= w_adr_err;
                if (!wb_we_i && !w_adr_err && wb_sel_i != 4'd0)
                    r_rdat <= 32'd0;
            end
            if (r_state == S_ISSUE) begin
                r_pend     <= w_rest;
                r_cap_vld  <= !r_we && wb_cyc_i;
                r_cap_lane <= w_lane;
            end
            if (r_cap_vld &&
                (r_state == S_ISSUE || r_state == S_WAIT)) begin
                for (int i = 0; i < 4; i++)
                    if (r_cap_lane == i[1:0])
                        r_rdat[8*i +: 8] <= mem_dat_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_ctrl.sv
// Scoreboard bench for mem_wb_ctrl with a behavioural byte memory.
// Terminations are checked by a monitor against queued expectations.
module tb_mem_wb_ctrl;
    import mem_wb_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [31:0] wb_adr_i = 32'd0;
    logic [3:0]  wb_sel_i = 4'd0;
    logic [31:0] wb_dat_i = 32'd0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic [13:0] mem_adr;
    logic [7:0]  mem_dat_o;
    logic [7:0]  mem_dat_i;
    logic        mem_en;
    logic        mem_we;

    always #5 clk = ~clk;

    mem_wb_ctrl #(.AW(14)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_we_i   (wb_we_i),
        .wb_adr_i  (wb_adr_i),
        .wb_sel_i  (wb_sel_i),
        .wb_dat_i  (wb_dat_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .wb_err_o  (wb_err_o),
        .mem_adr   (mem_adr),
        .mem_dat_o (mem_dat_o),
        .mem_dat_i (mem_dat_i),
        .mem_en    (mem_en),
        .mem_we    (mem_we)
    );

    logic [7:0]  mem [0:MEM_SIZE-1];
    logic [7:0]  mem_rd = 8'd0;
    logic        pl_en = 1'b0;
    logic [13:0] pl_adr = 14'd0;
    logic [7:0]  pl_dat = 8'd0;

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_adr] <= pl_dat;
        else if (mem_en) begin
            if (mem_we)
                mem[mem_adr] <= mem_dat_o;
            else
                mem_rd <= mem[mem_adr];
        end
    end
    assign mem_dat_i = mem_rd;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    int          en_cnt = 0;
    int          we_cnt = 0;
    logic [13:0] adr_q[$];

    always @(negedge clk) begin
        if (mem_en) begin
            en_cnt = en_cnt + 1;
            adr_q.push_back(mem_adr);
        end
        if (mem_we)
            we_cnt = we_cnt + 1;
    end

    int nchk = 0;
    int nerr = 0;

    task automatic check(input string n, input logic [31:0] a,
                         input logic [31:0] r);
        nchk = nchk + 1;
        if (a !== r) begin
            nerr = nerr + 1;
            $display("FAIL %s actual=%h required=%h", n, a, r);
        end
    endtask

    typedef struct {
        bit          err;
        bit          chkd;
        logic [31:0] dat;
        int          t;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        if (wb_ack_o || wb_err_o) begin
            if (sb.size() == 0) begin
                nchk = nchk + 1;
                nerr = nerr + 1;
                $display("FAIL unexpected_term actual ack=%0b err=%0b required none",
                         wb_ack_o, wb_err_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("term_kind", {30'd0, wb_err_o, wb_ack_o},
                      e.err ? 32'd2 : 32'd1);
                check("term_cycle", 32'(cyc_cnt), 32'(e.t));
                if (e.chkd)
                    check("rdata", wb_dat_o, e.dat);
            end
        end
    end

    task automatic preload(input logic [13:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_adr = a; pl_dat = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic req(input bit we, input logic [31:0] adr,
                       input logic [3:0] sel, input logic [31:0] dat,
                       input bit err, input bit chkd,
                       input logic [31:0] exp_d, input int lat,
                       input int abort_at);
        int  t0;
        bit  done;
        exp_t e;
        @(posedge clk);
        #1;
        en_cnt = 0; we_cnt = 0; adr_q.delete();
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat;
        t0 = cyc_cnt;
        if (abort_at == 0) begin
            e.err = err; e.chkd = chkd; e.dat = exp_d; e.t = t0 + lat;
            sb.push_back(e);
        end
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (abort_at > 0 && cyc_cnt == t0 + abort_at) done = 1'b1;
            else if (wb_ack_o || wb_err_o) done = 1'b1;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        if (!done) begin
            nchk = nchk + 1;
            nerr = nerr + 1;
            $display("FAIL timeout actual=no_term required=term adr=%h", adr);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs",
              {wb_dat_o[15:0] | wb_dat_o[31:16], 2'b00, wb_ack_o, wb_err_o,
               mem_adr[11:0] | {10'd0, mem_adr[13:12]}},
              32'd0);
        check("rst_mem_ctl", {mem_dat_o, 22'd0, mem_en, mem_we}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        preload(14'h2000, 8'h9C);
        preload(14'h2003, 8'hD7);
        preload(14'h0204, 8'h55);
        preload(14'h0205, 8'h66);
        preload(14'h0206, 8'h00);
        preload(14'h0207, 8'h00);
        preload(14'h0302, 8'h11);
        preload(14'h0303, 8'h22);

        req(1'b1, 32'h100, 4'hF, 32'h12345678, 1'b0, 1'b0, 32'd0, 5, 0);
        check("word_wr_mem", {mem[14'h100], mem[14'h101],
                              mem[14'h102], mem[14'h103]}, 32'h12345678);
        check("word_wr_we_cnt", 32'(we_cnt), 32'd4);

        req(1'b0, 32'h100, 4'hF, 32'd0, 1'b0, 1'b1, 32'h12345678, 6, 0);
        check("word_rd_en_cnt", 32'(en_cnt), 32'd4);

        req(1'b0, 32'h2000, 4'b1001, 32'd0, 1'b0, 1'b1, 32'h9C0000D7, 4, 0);
        check("sparse_en_cnt", 32'(en_cnt), 32'd2);
        if (adr_q.size() >= 2)
            check("sparse_adrs", {2'b0, adr_q[0], 2'b0, adr_q[1]},
                  32'h2000_2003);
        else
            check("sparse_adr_q_size", 32'(adr_q.size()), 32'd2);

        req(1'b1, 32'h204, 4'b0011, 32'hAAAABBBB, 1'b0, 1'b0, 32'd0, 3, 0);
        check("half_wr_we_cnt", 32'(we_cnt), 32'd2);
        check("half_wr_mem", {mem[14'h204], mem[14'h205],
                              mem[14'h206], mem[14'h207]}, 32'h5566BBBB);

        req(1'b0, 32'h204, 4'b0010, 32'd0, 1'b0, 1'b1, 32'h0000BB00, 3, 0);

        req(1'b0, 32'h4000, 4'hF, 32'd0, 1'b1, 1'b0, 32'd0, 1, 0);
        check("err_no_en", 32'(en_cnt), 32'd0);

        req(1'b1, 32'h108, 4'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0, 1, 0);
        check("sel0_no_en", 32'(en_cnt), 32'd0);

        req(1'b0, 32'h100, 4'hF, 32'd0, 1'b0, 1'b0, 32'd0, 0, 2);
        repeat (6) @(negedge clk);
        check("abort_en_cnt", 32'(en_cnt), 32'd2);
        req(1'b0, 32'h100, 4'hF, 32'd0, 1'b0, 1'b1, 32'h12345678, 6, 0);

        @(posedge clk);
        #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 32'h300; wb_sel_i = 4'hF; wb_dat_i = 32'hCAFEBABE;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_dat_o", wb_dat_o, 32'd0);
        check("midrst_ctl", {mem_dat_o, 2'b0, mem_adr, 4'b0,
                             wb_ack_o, wb_err_o, mem_en, mem_we}, 32'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_mem", {mem[14'h300], mem[14'h301],
                             mem[14'h302], mem[14'h303]}, 32'hCAFE1122);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mem_wb_ctrl.md
# mem_wb_ctrl

Wishbone slave controller that gives the 32-bit OpenRISC bus access to the byte-wide 16 KB on-chip memory (the eight-bank 2 KB block-RAM array with 14-bit byte address and 1-cycle synchronous read). It decomposes each word, halfword or byte access into sequential byte accesses. Read bytes are assembled big-endian, and the transfer is terminated with a single-cycle ack or err. It sits between the bus interconnect and the memory instance; the memory's `rst` (SSR) is driven at top level, not by this block.

## Interface
- `AW`, 14: memory byte-address width.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `wb_cyc_i` in 1: bus cycle.
- `wb_stb_i` in 1: strobe.
- `wb_we_i` in 1: 1 = write.
- `wb_adr_i` in 32: byte address; bits [1:0] ignored.
- `wb_sel_i` in 4: byte-lane enables; sel[3] = dat[31:24] = byte offset 0.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: read data.
- `wb_ack_o` out 1: normal termination, 1-cycle pulse.
- `wb_err_o` out 1: error termination, 1-cycle pulse.
- `mem_adr` out AW: memory byte address.
- `mem_dat_o` out 8: write byte to memory.
- `mem_dat_i` in 8: read byte from memory, valid the cycle after an enabled read.
- `mem_en` out 1: memory enable.
- `mem_we` out 1: memory write enable.

## Operation
- FSM states: IDLE, ISSUE, WAIT, TERM.
- **IDLE**
  - On cyc&stb, latch word address adr[AW-1:2], sel, we and dat_i.
  - If adr[31:AW] != 0: go to TERM with err.
  - Else if sel == 0: go to TERM with ack.
  - Else: go to ISSUE. On a read, wb_dat_o clears to 0.
- **ISSUE**
  - Each cycle serves the highest-numbered remaining set sel bit (lane L) and clears it from the pending mask.
  - Outputs that cycle: mem_en=1, mem_we=we, mem_adr={word, 3−L}, mem_dat_o=dat_i byte of lane L.
  - After the last lane: write goes to TERM; read goes to WAIT.
- **Read capture**
  - The byte on mem_dat_i in the cycle after a lane is issued is written into wb_dat_o[8L+7:8L].
  - Capture overlaps the next issue (pipelined).
  - WAIT captures the final byte, then goes to TERM.
- **TERM**
  - Assert ack (or err) for exactly one cycle, then go to IDLE.
  - Unselected wb_dat_o bytes are 0.
  - wb_dat_o holds its value until the next read starts.
- **Abort:** cyc deasserted in ISSUE or WAIT → IDLE next cycle, no ack/err. Memory writes already issued remain.
- A new request is sampled no earlier than the IDLE cycle after TERM.
- mem_en=0 in IDLE, WAIT and TERM.
- mem_adr and mem_dat_o are 0 when mem_en=0.

## Timing
- **Reset (rst low):** immediately go to IDLE. All outputs 0: wb_dat_o, wb_ack_o, wb_err_o, mem_adr, mem_dat_o, mem_en, mem_we.
- **Reset mid-access:** the access is dropped with no termination. A write byte already clocked into memory stays.
- **Cycle numbering:** C0 = IDLE cycle where cyc&stb is sampled. N = popcount(sel).
- Memory issue occurs in C1..CN.
- **Write:** ack in C(N+1).
- **Read:** WAIT in C(N+1), ack in C(N+2); wb_dat_o is valid with ack.
- sel == 0 or address error: ack/err in C1.
- Throughput for back-to-back word reads: one per 7 cycles (IDLE + 4 ISSUE + WAIT + TERM).
- Non-contiguous sel (e.g. 4'b1001) is legal: lanes 3 then 0, N=2.

## Structure
- **Shared package/header:**
  - FSM state encoding.
  - Lane-to-offset mapping (offset = 3 − lane).
  - AW default.
  - Memory size constant (1<<AW).
- **Sub-module `mem_lane_pick`:** combinational priority encoder.
  - Input: 4-bit pending mask.
  - Outputs: lane index, valid, mask-with-lane-cleared.
- The FSM, capture datapath and output registers live in mem_wb_ctrl.

## Test plan
- **Reset:** rst low during ISSUE of a word write → all outputs 0 the same cycle. Memory model shows only the bytes issued before reset changed.
- **Word write/read:** write 0x12345678 sel=F to adr 0x100.
  - Memory bytes 0x100..0x103 = 12,34,56,78.
  - ack at C5.
  - Read back returns 0x12345678 with ack at C6.
- **Sparse sel:** read adr 0x2000 sel=4'b1001 with memory 0x2000=0x9C, 0x2003=0xD7 → wb_dat_o=0x9C0000D7, ack at C4, exactly 2 mem_en cycles (adr 0x2000, 0x2003).
- **Halfword write:** data 0xAAAABBBB, sel=4'b0011, adr 0x0204 → only 0x206=0xBB, 0x207=0xBB written; mem_we high exactly 2 cycles.
- **Errors/empty:**
  - adr 0x0000_4000 → err at C1, no mem_en, no ack.
  - sel=0 → ack at C1, no mem_en.
- **Abort:** cyc dropped at C2 of a word read → IDLE at C3, no ack; the next request issues normally.
